// File: rtl/psg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psg_pkg
// Purpose  : Shared register indices, widths and helpers for the PSG blocks.
// Revision : 1.0
// ============================================================================
package psg_pkg;

  // Latched register index: bits 2:1 = channel, bit 0 = 1 for attenuation.
  localparam logic [2:0] TONE0 = 3'd0;
  localparam logic [2:0] ATT0  = 3'd1;
  localparam logic [2:0] TONE1 = 3'd2;
  localparam logic [2:0] ATT1  = 3'd3;
  localparam logic [2:0] TONE2 = 3'd4;
  localparam logic [2:0] ATT2  = 3'd5;
  localparam logic [2:0] NOISE = 3'd6;
  localparam logic [2:0] ATT_N = 3'd7;

  localparam int TONE_BITS     = 10;
  localparam int ATT_BITS      = 4;
  localparam int NOISE_BITS    = 3;
  localparam int BUSY_CNT_BITS = 8;

  localparam logic [3:0] ATT_SILENT = 4'hF;

  function automatic logic [1:0] reg_channel(input logic [2:0] idx);
    return idx[2:1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/psg_strobe_sync.sv
`default_nettype none
// ============================================================================
// Module   : psg_strobe_sync
// Purpose  : 2-FF synchroniser and falling-edge detector for an active-low strobe.
// Revision : 1.0
// ============================================================================
module psg_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_n,
  output logic fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;

  // All stages idle high so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 1'b1;
    end else begin
      r_sync1 <= async_n;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign fall = r_hist & ~r_sync2;

endmodule
`default_nettype wire

// File: rtl/psg_write_decoder.sv
`default_nettype none
// ============================================================================
// Module   : psg_write_decoder
// Purpose  : SN76489 bus write decoder and sound register file with READY window.
// Revision : 1.0
// ============================================================================
module psg_write_decoder
  import psg_pkg::*;
#(
  parameter int BUSY_CYCLES           = 32,
  parameter int TONE_FREQUENCY_BITS   = TONE_BITS,
  parameter int TONE_ATTENUATION_BITS = ATT_BITS,
  parameter int NOISE_CONTROL_BITS    = NOISE_BITS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [7:0]                         data_in,
  input  logic                               wr_n,
  output logic                               ready,
  output logic [3*TONE_FREQUENCY_BITS-1:0]   tone_period,
  output logic [4*TONE_ATTENUATION_BITS-1:0] attenuation,
  output logic [NOISE_CONTROL_BITS-1:0]      noise_ctrl,
  output logic                               noise_restart,
  output logic                               write_dropped
);

  localparam logic [BUSY_CNT_BITS-1:0] c_busy_load = BUSY_CNT_BITS'(BUSY_CYCLES);

  logic [TONE_FREQUENCY_BITS-1:0]   r_tone [0:2];
  logic [TONE_ATTENUATION_BITS-1:0] r_att  [0:3];
  logic [NOISE_CONTROL_BITS-1:0]    r_noise;
  logic [2:0]                       r_reg_idx;
  logic [BUSY_CNT_BITS-1:0]         r_busy_cnt;
  logic                             r_noise_restart;
  logic                             r_write_dropped;

  logic       w_fall;
  logic       w_accept;
  logic [2:0] w_idx;
  logic [1:0] w_ch;

  psg_strobe_sync u_strobe_sync (
    .clk     (clk),
    .reset   (reset),
    .async_n (wr_n),
    .fall    (w_fall)
  );

  assign ready    = (r_busy_cnt == '0);
  assign w_accept = w_fall & ready;
  // Data bytes reuse the last latched index; latch bytes carry their own.
  assign w_idx    = data_in[7] ? data_in[6:4] : r_reg_idx;
  assign w_ch     = reg_channel(w_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tone          <= '{default: '0};
      r_att           <= '{default: ATT_SILENT};
      r_noise         <= '0;
      r_reg_idx       <= TONE0;
      r_busy_cnt      <= '0;
      r_noise_restart <= 1'b0;
      r_write_dropped <= 1'b0;
    end else begin
      r_noise_restart <= 1'b0;
      r_write_dropped <= w_fall & ~ready;
      if (r_busy_cnt != '0) begin
        r_busy_cnt <= r_busy_cnt - 1'b1;
      end
      if (w_accept) begin
        r_busy_cnt <= c_busy_load;
        if (data_in[7]) begin
          r_reg_idx <= data_in[6:4];
        end
        case (w_idx)
          TONE0, TONE1, TONE2: begin
            if (data_in[7]) begin
              r_tone[w_ch][3:0] <= data_in[3:0];
            end else begin
              r_tone[w_ch][TONE_FREQUENCY_BITS-1:4] <= data_in[5:0];
            end
          end
          ATT0, ATT1, ATT2, ATT_N: begin
            r_att[w_ch] <= data_in[TONE_ATTENUATION_BITS-1:0];
          end
          NOISE: begin
            r_noise         <= data_in[NOISE_CONTROL_BITS-1:0];
            r_noise_restart <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tone_period   = {r_tone[2], r_tone[1], r_tone[0]};
  assign attenuation   = {r_att[3], r_att[2], r_att[1], r_att[0]};
  assign noise_ctrl    = r_noise;
  assign noise_restart = r_noise_restart;
  assign write_dropped = r_write_dropped;

endmodule
`default_nettype wire

// File: tb/tb_psg_write_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_psg_write_decoder
// Purpose  : Scoreboard bench for psg_write_decoder against a register-level model.
// Revision : 1.0
// ============================================================================
module tb_psg_write_decoder;

  localparam int BUSY = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_n = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        ready;
  logic [29:0] tone_period;
  logic [15:0] attenuation;
  logic [2:0]  noise_ctrl;
  logic        noise_restart;
  logic        write_dropped;

  psg_write_decoder #(.BUSY_CYCLES(BUSY)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .wr_n          (wr_n),
    .ready         (ready),
    .tone_period   (tone_period),
    .attenuation   (attenuation),
    .noise_ctrl    (noise_ctrl),
    .noise_restart (noise_restart),
    .write_dropped (write_dropped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic        drop;
    logic        restart;
    logic [29:0] tp;
    logic [15:0] at;
    logic [2:0]  nc;
    int          cyc;
  } ev_t;

  ev_t q[$];

  // Reference model: plain register contents plus the cycle the busy window ends.
  int m_tone[3];
  int m_att[4];
  int m_noise;
  int m_idx;
  int busy_until;

  task automatic model_reset();
    m_tone = '{0, 0, 0};
    m_att = '{15, 15, 15, 15};
    m_noise = 0;
    m_idx = 0;
    busy_until = 0;
  endtask

  task automatic model_write(input logic [7:0] b, input int acc_cyc);
    ev_t e;
    int ch;
    int vol;
    e.drop = 1'b0;
    e.restart = 1'b0;
    if (acc_cyc <= busy_until) begin
      e.drop = 1'b1;
    end else begin
      busy_until = acc_cyc + BUSY;
      if (b[7]) m_idx = int'(b[6:4]);
      ch = m_idx / 2;
      vol = m_idx % 2;
      if (vol == 1) m_att[ch] = b % 16;
      else if (ch == 3) begin
        m_noise = b % 8;
        e.restart = 1'b1;
      end else if (b[7]) m_tone[ch] = (m_tone[ch] / 16) * 16 + b % 16;
      else m_tone[ch] = (b % 64) * 16 + m_tone[ch] % 16;
    end
    e.tp = {m_tone[2][9:0], m_tone[1][9:0], m_tone[0][9:0]};
    e.at = {m_att[3][3:0], m_att[2][3:0], m_att[1][3:0], m_att[0][3:0]};
    e.nc = m_noise[2:0];
    e.cyc = acc_cyc;
    q.push_back(e);
  endtask

  // Strobe low at cycle c: the register update is due after edge c+3 of the counter.
  task automatic do_write(input logic [7:0] b, input int hold);
    @(negedge clk);
    data_in = b;
    wr_n = 1'b0;
    model_write(b, cyc + 3);
    repeat (hold) @(negedge clk);
    wr_n = 1'b1;
    data_in = 8'($urandom);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!ready) chk("ready_timeout", ready, 1);
  endtask

  // Monitor: an event is a READY fall (accepted write) or a write_dropped pulse.
  logic prev_ready = 1'b1;
  int   low_run = 0;
  ev_t  shadow;
  ev_t  e_mon;
  logic ev;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ready = 1'b1;
        low_run = 0;
        shadow.tp = '0;
        shadow.at = 16'hFFFF;
        shadow.nc = '0;
      end else begin
        ev = (prev_ready && !ready) || write_dropped;
        if (ev) begin
          if (q.size() == 0) begin
            chk("event_pending", q.size(), 1);
          end else begin
            e_mon = q.pop_front();
            chk("event_cycle", cyc, e_mon.cyc);
            chk("tone_period", tone_period, e_mon.tp);
            chk("attenuation", attenuation, e_mon.at);
            chk("noise_ctrl", noise_ctrl, e_mon.nc);
            chk("noise_restart", noise_restart, e_mon.restart);
            chk("write_dropped", write_dropped, e_mon.drop);
            chk("ready_on_event", ready, 0);
            shadow = e_mon;
          end
        end else begin
          chk("idle_stable", {tone_period, attenuation, noise_ctrl, noise_restart, write_dropped},
              {shadow.tp, shadow.at, shadow.nc, 2'b00});
        end
        if (!prev_ready && ready) chk("busy_len", low_run, BUSY);
        low_run = ready ? 0 : low_run + 1;
        prev_ready = ready;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_tone"}, tone_period, 30'd0);
    chk({tag, "_att"}, attenuation, 16'hFFFF);
    chk({tag, "_noise"}, noise_ctrl, 3'd0);
    chk({tag, "_ready"}, ready, 1'b1);
    chk({tag, "_pulses"}, {noise_restart, write_dropped}, 2'b00);
  endtask

  initial begin
    int k;
    logic [7:0] b;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_values("rst");
    repeat (100) @(negedge clk);

    do_write(8'h8E, 3);
    wait_ready();
    do_write(8'h0F, 3);
    wait_ready();
    chk("tone0", tone_period[9:0], 10'h0FE);

    do_write(8'hD5, 4);
    wait_ready();
    chk("att2_latch", attenuation[11:8], 4'd5);
    chk("att_others", {attenuation[15:12], attenuation[7:0]}, 12'hFFF);
    do_write(8'h03, 3);
    wait_ready();
    chk("att2_data", attenuation[11:8], 4'd3);

    do_write(8'hE5, 3);
    wait_ready();
    chk("noise_latch", noise_ctrl, 3'b101);
    do_write(8'h02, 3);
    wait_ready();
    chk("noise_data", noise_ctrl, 3'b010);

    do_write(8'hA1, 3);
    do_write(8'h9C, 3);
    wait_ready();
    chk("tone1_lo", tone_period[13:10], 4'd1);
    chk("att0_kept", attenuation[3:0], 4'hF);

    repeat (60) begin
      b = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        wait_ready();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      do_write(b, $urandom_range(3, 6));
    end

    // Reset mid-busy with the strobe still held low.
    wait_ready();
    @(negedge clk);
    data_in = 8'h9A;
    wr_n = 1'b0;
    model_write(8'h9A, cyc + 3);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    model_reset();
    q.delete();
    @(negedge clk);
    check_reset_values("rst_busy");
    wr_n = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_reset_ready", ready, 1'b1);

    do_write(8'h2A, 3);
    wait_ready();
    chk("data_before_latch", tone_period[9:0], 10'h2A0);

    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("queue_drained", q.size(), 0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
